// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcode/funct
// constants, datapath select codes and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // NOP is zero so that an idle controller drives an all-zero output bundle.
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  // Opcodes 0x08..0x0F are the immediate-arithmetic group.
  function automatic logic is_iarith(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational op/funct decoder: ALU operation, immediate extension mode and
// instruction legality for the supported MIPS subset.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_ext_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_NOP;
    o_ext_op = 1'b1;
    o_legal  = 1'b1;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          F_ADD, F_ADDU: o_alu_op = ALU_ADD;
          F_SUB, F_SUBU: o_alu_op = ALU_SUB;
          F_AND:         o_alu_op = ALU_AND;
          F_OR:          o_alu_op = ALU_OR;
          F_XOR:         o_alu_op = ALU_XOR;
          F_NOR:         o_alu_op = ALU_NOR;
          F_SLT:         o_alu_op = ALU_SLT;
          F_SLTU:        o_alu_op = ALU_SLTU;
          F_SLL:         o_alu_op = ALU_SLL;
          F_SRL:         o_alu_op = ALU_SRL;
          F_SLLV:        o_alu_op = ALU_SLLV;
          default:       o_legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: o_alu_op = ALU_ADD;
      OP_SLTI:  o_alu_op = ALU_SLT;
      OP_SLTIU: o_alu_op = ALU_SLTU;
      // Logical immediates and lui take a zero-extended immediate.
      OP_ANDI: begin o_alu_op = ALU_AND; o_ext_op = 1'b0; end
      OP_ORI:  begin o_alu_op = ALU_OR;  o_ext_op = 1'b0; end
      OP_XORI: begin o_alu_op = ALU_XOR; o_ext_op = 1'b0; end
      OP_LUI:  begin o_alu_op = ALU_LUI; o_ext_op = 1'b0; end
      OP_BEQ, OP_BNE: o_alu_op = ALU_SUB;
      OP_J: ;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM sequencing the shared ALU through IF/ID/EXE/MEM/WB.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                imem_req,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_srca,
  output logic [1:0]          alu_srcb,
  output logic                ext_op,
  output logic [3:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic [RETIRE_W-1:0] insn_retired
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_ext_op;
  logic       w_dec_legal;

  mc_alu_dec u_alu_dec (
    .i_op     (op),
    .i_funct  (funct),
    .o_alu_op (w_dec_alu_op),
    .o_ext_op (w_dec_ext_op),
    .o_legal  (w_dec_legal)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_srca   = 1'b0;
    alu_srcb   = SRCB_REG;
    ext_op     = 1'b0;
    alu_op     = ALU_NOP;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        alu_srcb = SRCB_FOUR;
        alu_op   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_ID;
        end
      end
      ST_ID: begin
        // Branch target is computed speculatively while the opcode is decoded.
        alu_srcb = SRCB_BRANCH;
        ext_op   = 1'b1;
        alu_op   = ALU_ADD;
        if (!w_dec_legal) begin
          illegal = 1'b1;
          w_next  = ST_IF;
        end else if (op == OP_J) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          w_next   = ST_IF;
        end else begin
          w_next = ST_EXE;
        end
      end
      ST_EXE: begin
        alu_srca = 1'b1;
        w_next   = ST_IF;
        if (op == OP_RTYPE) begin
          alu_op = w_dec_alu_op;
          w_next = ST_WB;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          alu_op   = ALU_SUB;
          pc_src   = PC_SRC_ALUOUT;
          pc_write = (op == OP_BEQ) ? zero : ~zero;
        end else if (is_iarith(op) || op == OP_LW || op == OP_SW) begin
          alu_srcb = SRCB_IMM;
          ext_op   = w_dec_ext_op;
          alu_op   = w_dec_alu_op;
          w_next   = is_iarith(op) ? ST_WB : ST_MEM;
        end
      end
      ST_MEM: begin
        dmem_rd = (op == OP_LW);
        dmem_wr = (op == OP_SW);
        if (mem_ready) w_next = (op == OP_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = (op == OP_LW);
        w_next     = ST_IF;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic [RETIRE_W-1:0] r_retired;
  logic                w_retire;

  // Every edge that returns to IF after a legal instruction retires it.
  assign w_retire = (r_state == ST_WB)
                 || (r_state == ST_MEM && op == OP_SW && mem_ready)
                 || (r_state == ST_EXE && (op == OP_BEQ || op == OP_BNE))
                 || (r_state == ST_ID && op == OP_J && w_dec_legal);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
  end

  assign insn_retired = r_retired;
`else
  assign insn_retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued
// with their stimulus and compared as the FSM steps through each instruction.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          imem_req, dmem_rd, dmem_wr, ir_write, pc_write;
  logic [1:0]    pc_src, alu_srcb;
  logic          alu_srca, ext_op, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0]    alu_op;
  logic [RW-1:0] insn_retired;
  logic [18:0]   ctl;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic        z;
    logic [18:0] ctl;
    string       name;
  } exp_t;
  exp_t sb[$];

  mc_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .ext_op(ext_op), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .insn_retired(insn_retired)
  );

  assign ctl = {imem_req, dmem_rd, dmem_wr, ir_write, pc_write, pc_src,
                alu_srca, alu_srcb, ext_op, alu_op,
                reg_write, reg_dst, mem_to_reg, illegal};

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(
      input logic imem, input logic rd, input logic wr, input logic irw,
      input logic pcw, input logic [1:0] pcs, input logic sa,
      input logic [1:0] sbs, input logic ext, input logic [3:0] aop,
      input logic rw, input logic rdst, input logic m2r, input logic ill);
    return {imem, rd, wr, irw, pcw, pcs, sa, sbs, ext, aop, rw, rdst, m2r, ill};
  endfunction

  function automatic logic [18:0] v_if(input logic mr);
    return mk(1, 0, 0, mr, mr, 2'b00, 0, 2'b01, 0, ALU_ADD, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] v_id(input logic pcw, input logic [1:0] pcs, input logic ill);
    return mk(0, 0, 0, 0, pcw, pcs, 0, 2'b11, 1, ALU_ADD, 0, 0, 0, ill);
  endfunction
  function automatic logic [18:0] v_exe(input logic pcw, input logic [1:0] pcs,
      input logic [1:0] sbs, input logic ext, input logic [3:0] aop);
    return mk(0, 0, 0, 0, pcw, pcs, 1, sbs, ext, aop, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] v_mem(input logic rd, input logic wr);
    return mk(0, rd, wr, 0, 0, 2'b00, 0, 2'b00, 0, ALU_NOP, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] v_wb(input logic rdst, input logic m2r);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, ALU_NOP, 1, rdst, m2r, 0);
  endfunction

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic mr,
                      input logic z, input logic [18:0] c, input string nm);
    exp_t e;
    e.op = o; e.funct = f; e.mr = mr; e.z = z; e.ctl = c; e.name = nm;
    sb.push_back(e);
  endtask

  // Full IF/ID/EXE/WB sequence for an ALU-class instruction.
  task automatic push_alu(input logic [5:0] o, input logic [5:0] f, input logic [1:0] sbs,
                          input logic ext, input logic [3:0] aop, input logic rdst,
                          input string nm);
    push(o, f, 1, 0, v_if(1), {nm, "_if"});
    push(o, f, 1, 1, v_id(0, 2'b00, 0), {nm, "_id"});
    push(o, f, 1, 0, v_exe(0, 2'b00, sbs, ext, aop), {nm, "_exe"});
    push(o, f, 0, 1, v_wb(rdst, 0), {nm, "_wb"});
  endtask

  task automatic push_j(input string nm);
    push(OP_J, 6'h00, 1, 0, v_if(1), {nm, "_if"});
    push(OP_J, 6'h00, 0, 0, v_id(1, 2'b10, 0), {nm, "_id"});
  endtask

  task automatic test_reset;
    exp_t e;
    #2;
    n_cmp++;
    if (ctl !== 19'd0) begin n_err++; $display("FAIL reset_ctl: got %05h want %05h", ctl, 19'd0); end
    @(negedge clk); rstn = 1'b1; #1;
    n_cmp++;
    if (ctl !== 19'd0) begin n_err++; $display("FAIL idle_ctl: got %05h want %05h", ctl, 19'd0); end
    push(OP_SW, 6'h00, 1, 0, v_if(1), "rst_sw_if");
    push(OP_SW, 6'h00, 0, 0, v_id(0, 2'b00, 0), "rst_sw_id");
    push(OP_SW, 6'h00, 0, 0, v_exe(0, 2'b00, 2'b10, 1, ALU_ADD), "rst_sw_exe");
    push(OP_SW, 6'h00, 0, 0, v_mem(0, 1), "rst_sw_mem0");
    push(OP_SW, 6'h00, 0, 0, v_mem(0, 1), "rst_sw_mem1");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
    #1; rstn = 1'b0; #1;
    n_cmp++;
    if (dmem_wr !== 1'b0 || ctl !== 19'd0)
      begin n_err++; $display("FAIL reset_in_mem: got %05h want %05h", ctl, 19'd0); end
    @(negedge clk); rstn = 1'b1; #1;
    n_cmp++;
    if (ctl !== 19'd0) begin n_err++; $display("FAIL idle_after_abort: got %05h want %05h", ctl, 19'd0); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++;
    if (ctl !== v_if(0)) begin n_err++; $display("FAIL if_after_reset: got %05h want %05h", ctl, v_if(0)); end
  endtask

  task automatic test_alu_decode;
    exp_t e;
    push_alu(OP_RTYPE, F_ADDU, 2'b00, 0, ALU_ADD, 1, "addu");
    push_alu(OP_RTYPE, F_SUBU, 2'b00, 0, ALU_SUB, 1, "subu");
    push_alu(OP_RTYPE, F_NOR,  2'b00, 0, ALU_NOR, 1, "nor");
    push_alu(OP_RTYPE, F_SLLV, 2'b00, 0, ALU_SLLV, 1, "sllv");
    push_alu(OP_RTYPE, F_SLTU, 2'b00, 0, ALU_SLTU, 1, "sltu");
    push_alu(OP_ORI,   6'h25,  2'b10, 0, ALU_OR,  0, "ori");
    push_alu(OP_SLTI,  6'h00,  2'b10, 1, ALU_SLT, 0, "slti");
    push_alu(OP_LUI,   6'h00,  2'b10, 0, ALU_LUI, 0, "lui");
    push_alu(OP_ADDIU, 6'h00,  2'b10, 1, ALU_ADD, 0, "addiu");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
  endtask

  task automatic test_lw_wait;
    exp_t e;
    push(OP_LW, 6'h00, 0, 0, v_if(0), "lw_if_wait");
    push(OP_LW, 6'h00, 1, 0, v_if(1), "lw_if");
    push(OP_LW, 6'h00, 1, 0, v_id(0, 2'b00, 0), "lw_id");
    push(OP_LW, 6'h00, 1, 1, v_exe(0, 2'b00, 2'b10, 1, ALU_ADD), "lw_exe");
    for (int i = 0; i < 3; i++) push(OP_LW, 6'h00, 0, 0, v_mem(1, 0), $sformatf("lw_mem_wait%0d", i));
    push(OP_LW, 6'h00, 1, 0, v_mem(1, 0), "lw_mem_done");
    push(OP_LW, 6'h00, 1, 0, v_wb(0, 1), "lw_wb");
    push(OP_LW, 6'h00, 0, 0, v_if(0), "lw_back_if");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [5:0] bop [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       bz  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       bpw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push(bop[i], 6'h00, 1, 0, v_if(1), $sformatf("br%0d_if", i));
      push(bop[i], 6'h00, 1, 0, v_id(0, 2'b00, 0), $sformatf("br%0d_id", i));
      push(bop[i], 6'h00, 0, bz[i], v_exe(bpw[i], 2'b01, 2'b00, 0, ALU_SUB), $sformatf("br%0d_exe", i));
    end
    push(OP_SW, 6'h00, 1, 0, v_if(1), "sw_if");
    push(OP_SW, 6'h00, 0, 0, v_id(0, 2'b00, 0), "sw_id");
    push(OP_SW, 6'h00, 0, 0, v_exe(0, 2'b00, 2'b10, 1, ALU_ADD), "sw_exe");
    push(OP_SW, 6'h00, 0, 0, v_mem(0, 1), "sw_mem_wait");
    push(OP_SW, 6'h00, 1, 0, v_mem(0, 1), "sw_mem_done");
    push_j("j");
    push(OP_J, 6'h00, 0, 0, v_if(0), "j_back_if");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    push(6'h3F, 6'h00, 1, 0, v_if(1), "ill_op_if");
    push(6'h3F, 6'h00, 1, 0, v_id(0, 2'b00, 1), "ill_op_id");
    push(OP_RTYPE, 6'h3F, 1, 0, v_if(1), "ill_funct_if");
    push(OP_RTYPE, 6'h3F, 1, 0, v_id(0, 2'b00, 1), "ill_funct_id");
    push(6'h10, 6'h20, 1, 0, v_if(1), "ill_cop_if");
    push(6'h10, 6'h20, 0, 0, v_id(0, 2'b00, 1), "ill_cop_id");
    push(6'h10, 6'h20, 0, 0, v_if(0), "ill_next_if");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
  endtask

  task automatic test_perf;
    exp_t e;
    logic [RW-1:0] exp3, expf, exp0;
`ifdef MC_CTRL_PERF_CNT_EN
    exp3 = RW'(3); expf = {RW{1'b1}}; exp0 = '0;
`else
    exp3 = '0; expf = '0; exp0 = '0;
`endif
    @(negedge clk); rstn = 1'b0; #1;
    n_cmp++;
    if (insn_retired !== '0) begin n_err++; $display("FAIL perf_reset: got %0d want 0", insn_retired); end
    #2; rstn = 1'b1;
    push_alu(OP_RTYPE, F_ADDU, 2'b00, 0, ALU_ADD, 1, "perf_addu");
    push(OP_SW, 6'h00, 1, 0, v_if(1), "perf_sw_if");
    push(OP_SW, 6'h00, 1, 0, v_id(0, 2'b00, 0), "perf_sw_id");
    push(OP_SW, 6'h00, 1, 0, v_exe(0, 2'b00, 2'b10, 1, ALU_ADD), "perf_sw_exe");
    push(OP_SW, 6'h00, 1, 0, v_mem(0, 1), "perf_sw_mem");
    push(6'h3F, 6'h00, 1, 0, v_if(1), "perf_ill_if");
    push(6'h3F, 6'h00, 0, 0, v_id(0, 2'b00, 1), "perf_ill_id");
    push_j("perf_j");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++;
    if (insn_retired !== exp3) begin n_err++; $display("FAIL perf_count3: got %0d want %0d", insn_retired, exp3); end
    for (int i = 0; i < (2 ** RW) - 4; i++) push_j($sformatf("perf_fill%0d", i));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++;
    if (insn_retired !== expf) begin n_err++; $display("FAIL perf_all_ones: got %0d want %0d", insn_retired, expf); end
    push_j("perf_wrap");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); op = e.op; funct = e.funct; mem_ready = e.mr; zero = e.z; #1;
      n_cmp++;
      if (ctl !== e.ctl) begin n_err++; $display("FAIL %s: got %05h want %05h", e.name, ctl, e.ctl); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++;
    if (insn_retired !== exp0) begin n_err++; $display("FAIL perf_wrap: got %0d want %0d", insn_retired, exp0); end
  endtask

  initial begin
    rstn = 1'b0; op = OP_SW; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu_decode();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
